// File: rtl/enc_pkg.sv
// enc_pkg: shared state type and widths for the serial 8-to-3 encoder
package enc_pkg;
  localparam int VEC_W = 8;
  localparam int IDX_W = 3;
  typedef enum logic [1:0] {IDLE, EMIT, NONE} state_t;
endpackage

// File: rtl/enc8to3_serial_if.sv
// enc8to3_serial_if: vector-in / beat-out handshake bundle for enc8to3_serial
interface enc8to3_serial_if;
  import enc_pkg::*;
  logic [VEC_W-1:0] in;
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             out_none;
  modport master (
    output in, en, in_valid, out_ready,
    input  in_ready, out, out_valid, out_last, out_none
  );
  modport slave (
    input  in, en, in_valid, out_ready,
    output in_ready, out, out_valid, out_last, out_none
  );
endinterface

// File: rtl/enc8to3_serial_prio_enc8.sv
// prio_enc8: combinational 8-bit priority encoder, highest or lowest set bit first
module prio_enc8
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1
) (
  input  logic [VEC_W-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < VEC_W; i++)
      if (vec_i[MSB_FIRST ? i : VEC_W-1-i]) idx_o = IDX_W'(MSB_FIRST ? i : VEC_W-1-i);
  end
  assign any_o = |vec_i;
endmodule

// File: rtl/enc8to3_serial.sv
// enc8to3_serial: captures a multi-hot vector and emits one encoded index beat per set bit
module enc8to3_serial
  import enc_pkg::*;
#(
  parameter bit MSB_FIRST = 1
) (
  input logic               clk,
  input logic               rst,
  enc8to3_serial_if.slave   bus
);
  state_t           state_q, state_d;
  logic [VEC_W-1:0] pending_q, pending_d, cap_vec;
  logic [IDX_W-1:0] idx;
  logic             any, last, valid;
  prio_enc8 #(.MSB_FIRST(MSB_FIRST)) u_prio (
    .vec_i (pending_q),
    .idx_o (idx),
    .any_o (any)
  );
  assign last    = any && ((pending_q & (pending_q - VEC_W'(1))) == '0);
  assign cap_vec = bus.en ? bus.in : '0;
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        pending_d = cap_vec;
        state_d   = |cap_vec ? EMIT : NONE;
      end
      EMIT: if (bus.out_ready) begin
        pending_d = pending_q & ~(VEC_W'(1) << idx);
        state_d   = last ? IDLE : EMIT;
      end
      NONE: if (bus.out_ready) state_d = IDLE;
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end
  assign valid         = !rst && state_q != IDLE;
  assign bus.in_ready  = !rst && state_q == IDLE;
  assign bus.out_valid = valid;
  assign bus.out       = valid && state_q == EMIT ? idx : '0;
  assign bus.out_last  = valid && (state_q == NONE || last);
  assign bus.out_none  = valid && state_q == NONE;
endmodule

// File: tb/tb_enc8to3_serial.sv
// tb_enc8to3_serial: table-driven and sweep check of MSB-first and LSB-first encoders in lockstep
module tb_enc8to3_serial;
  typedef struct {
    logic [7:0] v;
    logic       e;
    int         beats;
    logic [2:0] fm;
    logic [2:0] fl;
  } vec_t;
  logic       clk = 0;
  logic       rst = 1;
  logic [7:0] in_r = 0;
  logic       en_r = 0;
  logic       iv_r = 0;
  logic       or_r = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  vec_t       tbl[10];
  always #5 clk = ~clk;
  enc8to3_serial_if bm();
  enc8to3_serial_if bl();
  assign bm.in = in_r;
  assign bm.en = en_r;
  assign bm.in_valid = iv_r;
  assign bm.out_ready = or_r;
  assign bl.in = in_r;
  assign bl.en = en_r;
  assign bl.in_valid = iv_r;
  assign bl.out_ready = or_r;
  enc8to3_serial #(.MSB_FIRST(1)) dut_m (.clk(clk), .rst(rst), .bus(bm.slave));
  enc8to3_serial #(.MSB_FIRST(0)) dut_l (.clk(clk), .rst(rst), .bus(bl.slave));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic offer(input logic [7:0] v, input logic e);
    int w;
    w = 0;
    while (!(bm.in_ready && bl.in_ready) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("in_ready before offer", {bm.in_ready, bl.in_ready}, 2'b11);
    in_r = v;
    en_r = e;
    iv_r = 1;
    @(negedge clk);
    iv_r = 0;
    in_r = 8'($urandom);
    en_r = 1'($urandom);
  endtask
  task automatic drain(input logic [7:0] v, input logic e, input bit rnd, input int exp_beats,
                       input bit chk_first, input logic [2:0] f_m, input logic [2:0] f_l);
    logic [7:0] p;
    int qm[$];
    int ql[$];
    int db, cyc;
    bit done, none;
    p = e ? v : 8'h00;
    none = (p == 8'h00);
    for (int i = 7; i >= 0; i--) if (p[i]) qm.push_back(i);
    for (int i = 0; i < 8; i++) if (p[i]) ql.push_back(i);
    if (none) begin
      qm.push_back(0);
      ql.push_back(0);
    end
    db = 0;
    cyc = 0;
    done = 0;
    while (!done && cyc < 100) begin
      or_r = rnd ? 1'($urandom) : 1'b1;
      check("out_valid", {bm.out_valid, bl.out_valid}, 2'b11);
      check("out msb-first", 32'(bm.out), db < qm.size() ? qm[db] : 8);
      check("out lsb-first", 32'(bl.out), db < ql.size() ? ql[db] : 8);
      check("out_last", {bm.out_last, bl.out_last}, (db == qm.size() - 1) ? 2'b11 : 2'b00);
      check("out_none", {bm.out_none, bl.out_none}, none ? 2'b11 : 2'b00);
      if (chk_first && db == 0) check("first beat", {bm.out, bl.out}, {f_m, f_l});
      if (bm.out_valid && or_r) begin
        db++;
        done = bm.out_last;
      end
      @(negedge clk);
      cyc++;
    end
    or_r = 0;
    check("beat count", db, exp_beats);
    check("bubble ready/valid", {bm.in_ready, bl.in_ready, bm.out_valid, bl.out_valid}, 4'b1100);
    check("idle outputs zero", {bm.out, bl.out, bm.out_last, bl.out_last, bm.out_none, bl.out_none}, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{8'hA5, 1'b1, 4, 3'd7, 3'd0};
    tbl[1] = '{8'hFF, 1'b0, 1, 3'd0, 3'd0};
    tbl[2] = '{8'h00, 1'b1, 1, 3'd0, 3'd0};
    tbl[3] = '{8'h80, 1'b1, 1, 3'd7, 3'd7};
    tbl[4] = '{8'h01, 1'b1, 1, 3'd0, 3'd0};
    tbl[5] = '{8'h3C, 1'b1, 4, 3'd5, 3'd2};
    tbl[6] = '{8'hFF, 1'b1, 8, 3'd7, 3'd0};
    tbl[7] = '{8'h12, 1'b1, 2, 3'd4, 3'd1};
    tbl[8] = '{8'h00, 1'b0, 1, 3'd0, 3'd0};
    tbl[9] = '{8'hC0, 1'b1, 2, 3'd7, 3'd6};
    repeat (3) @(negedge clk);
    check("reset in_ready", {bm.in_ready, bl.in_ready}, 2'b00);
    check("reset outputs", {bm.out_valid, bl.out_valid, bm.out, bl.out, bm.out_last, bl.out_last, bm.out_none, bl.out_none}, 0);
    rst = 0;
    @(negedge clk);
    check("in_ready after reset", {bm.in_ready, bl.in_ready}, 2'b11);
    foreach (tbl[i]) begin
      offer(tbl[i].v, tbl[i].e);
      drain(tbl[i].v, tbl[i].e, 0, tbl[i].beats, 1, tbl[i].fm, tbl[i].fl);
    end
    offer(8'h80, 1'b1);
    or_r = 0;
    for (int c = 0; c < 5; c++) begin
      check("stall valid", {bm.out_valid, bl.out_valid}, 2'b11);
      check("stall out", {bm.out, bl.out}, {3'd7, 3'd7});
      check("stall last", {bm.out_last, bl.out_last, bm.out_none, bl.out_none}, 4'b1100);
      @(negedge clk);
    end
    or_r = 1;
    check("stall 6th out", {bm.out_valid, bm.out, bl.out}, {1'b1, 3'd7, 3'd7});
    @(negedge clk);
    or_r = 0;
    check("stall release", {bm.in_ready, bl.in_ready, bm.out_valid, bl.out_valid}, 4'b1100);
    offer(8'hA5, 1'b1);
    or_r = 1;
    @(negedge clk);
    @(negedge clk);
    check("mid-vector beat", {bm.out, bl.out}, {3'd2, 3'd5});
    rst = 1;
    or_r = 0;
    @(negedge clk);
    check("mid reset outputs", {bm.out_valid, bl.out_valid, bm.out, bl.out, bm.out_last, bl.out_last}, 0);
    check("mid reset in_ready", {bm.in_ready, bl.in_ready}, 2'b00);
    rst = 0;
    @(negedge clk);
    check("post reset idle", {bm.in_ready, bl.in_ready, bm.out_valid, bl.out_valid}, 4'b1100);
    offer(8'h01, 1'b1);
    drain(8'h01, 1'b1, 0, 1, 1, 3'd0, 3'd0);
    for (int e = 0; e < 2; e++)
      for (int v = 0; v < 256; v++) begin
        offer(8'(v), 1'(e));
        drain(8'(v), 1'(e), 1, (e == 1 && v != 0) ? $countones(8'(v)) : 1, 0, 3'd0, 3'd0);
      end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/enc8to3_serial.md
ENC8TO3_SERIAL -- requirements
Module: enc8to3_serial

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1; 1 = emit set bits highest index first, 0 = lowest index first.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in  input  8  request vector (multi-hot allowed).
REQ-005 SHALL have port en  input  1  enable, sampled with in; en=0 treats vector as all-zero.
REQ-006 SHALL have port in_valid  input  1  producer offers in/en.
REQ-007 SHALL have port in_ready  output  1  block can accept a vector.
REQ-008 SHALL have port out  output  3  encoded index of current beat.
REQ-009 SHALL have port out_valid  output  1  out/out_last/out_none valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts beat.
REQ-011 SHALL have port out_last  output  1  final beat for current vector.
REQ-012 SHALL have port out_none  output  1  beat represents empty vector (out=0).

Function
REQ-013 SHALL implement FSM states IDLE, EMIT, NONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in EMIT or NONE.
REQ-015 IDLE: on in_valid&&in_ready, SHALL capture pending = en ? in : 8'h00; pending!=0 -> EMIT, pending==0 -> NONE.
REQ-016 Latency: first beat SHALL be valid the cycle after capture.
REQ-017 EMIT: out SHALL equal index of highest (MSB_FIRST=1) or lowest (MSB_FIRST=0) set bit of pending; out_none=0.
REQ-018 EMIT: out_last SHALL be 1 iff pending has exactly one bit set.
REQ-019 EMIT with out_ready=1: SHALL clear emitted bit in pending; if out_last -> IDLE, else stay EMIT.
REQ-020 NONE: SHALL present out=0, out_none=1, out_last=1; on out_ready -> IDLE.
REQ-021 With out_valid=1 and out_ready=0, out/out_last/out_none SHALL hold stable.
REQ-022 One bubble cycle (IDLE, in_ready=1) SHALL separate vectors; no same-cycle last-beat/capture overlap.
REQ-023 in/en changes outside an accepted handshake SHALL have no effect.
REQ-024 Beats per vector SHALL equal popcount (1..8), or exactly 1 for empty vector.
REQ-025 When out_valid=0, out, out_last, out_none SHALL be 0.

Reset
REQ-026 rst=1 at a clock edge SHALL force state=IDLE, pending=0, regardless of current state (mid-vector beats discarded).
REQ-027 During and after reset: out=0, out_valid=0, out_last=0, out_none=0; in_ready=0 while rst=1, 1 the first cycle after rst deasserts.

Structure
REQ-028 Shared package enc_pkg SHALL hold state enum (IDLE/EMIT/NONE), VEC_W=8, IDX_W=3.
REQ-029 SHALL contain one combinational sub-module prio_enc8 (8-bit vector + MSB_FIRST -> 3-bit index, any flag); FSM and pending register live in enc8to3_serial.

Verification
REQ-030 Reset mid-EMIT (in=8'hA5 accepted, 2 beats taken) -> after rst, out_valid=0, next vector 8'h01 yields single beat out=0, out_last=1.
REQ-031 MSB_FIRST=1, in=8'b1010_0101, en=1, out_ready=1 -> beats 7,5,2,0; out_last only on 0; 4 beats.
REQ-032 MSB_FIRST=0, same vector -> beats 0,2,5,7; out_last only on 7.
REQ-033 en=0, in=8'hFF -> single beat out=0, out_none=1, out_last=1; same for en=1, in=8'h00.
REQ-034 in=8'h80, out_ready held 0 for 5 cycles -> out=7, out_valid=1 stable all 5 cycles; accepted on 6th; in_ready=1 next cycle.
REQ-035 All 256 vectors x en, random out_ready -> beat sequence matches popcount/order model; scoreboard reports zero mismatches.
